// File: rtl/word_loader_pkg.sv
// Shared types and constants for the encoder's upstream word loader.
package word_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TERM0,
    TERM1,
    RUN,
    FIN
  } loader_state;

  // Byte value that separates words in the encoder's input SRAM.
  localparam int SEPARATOR = 0;

  // Entries reserved at the end of the SRAM for the double-zero terminator.
  localparam int TERM_ENTRIES = 2;

endpackage

// File: rtl/word_loader.sv
// Loads a byte stream into the encoder input SRAM as zero-separated words,
// appends the double-zero terminator, then runs the encoder to completion.
module word_loader
  import word_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  enc_cs,
  input  logic                  enc_done,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // Payload stops here so both terminator entries always fit without wrap.
  localparam logic [ADDR_WIDTH:0] PAYLOAD_MAX = (ADDR_WIDTH + 1)'(DEPTH - TERM_ENTRIES);
  localparam logic [DATA_WIDTH-1:0] SEP = DATA_WIDTH'(SEPARATOR);

  loader_state             state;
  logic [ADDR_WIDTH:0]     ptr;
  logic                    prev_zero;

  logic                    accept;
  logic                    byte_zero;
  logic                    room;
  logic                    do_write;
  logic                    zero_after;
  logic [ADDR_WIDTH:0]     ptr_after;

  assign in_ready   = (state == LOAD);
  assign count      = ptr;

  assign accept     = in_valid & in_ready;
  assign byte_zero  = (in_data == SEP);
  assign room       = (ptr < PAYLOAD_MAX);
  // A zero directly after a separator (or at the start) would form a
  // premature terminator, so only zeros following payload are kept.
  assign do_write   = accept & room & (~byte_zero | ~prev_zero);
  assign zero_after = do_write ? byte_zero : prev_zero;
  assign ptr_after  = do_write ? ptr + 1'b1 : ptr;

  // Control FSM with the registered SRAM write port and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      prev_zero <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      enc_cs    <= 1'b0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (cs) state <= LOAD;
        end
        LOAD: begin
          if (do_write) begin
            mem_we    <= 1'b1;
            mem_addr  <= ptr[ADDR_WIDTH-1:0];
            mem_din   <= in_data;
            ptr       <= ptr + 1'b1;
            prev_zero <= byte_zero;
          end
          if (accept && !byte_zero && !room) overflow <= 1'b1;
          // A trailing separator already provides the first terminator zero.
          if (accept && in_last) begin
            state <= (zero_after && (ptr_after != '0)) ? TERM1 : TERM0;
          end
        end
        TERM0: begin
          mem_we   <= 1'b1;
          mem_addr <= ptr[ADDR_WIDTH-1:0];
          mem_din  <= SEP;
          ptr      <= ptr + 1'b1;
          state    <= TERM1;
        end
        TERM1: begin
          mem_we   <= 1'b1;
          mem_addr <= ptr[ADDR_WIDTH-1:0];
          mem_din  <= SEP;
          ptr      <= ptr + 1'b1;
          state    <= RUN;
        end
        RUN: begin
          enc_cs <= 1'b1;
          // Only trust enc_done once the encoder has actually been started.
          if (enc_cs && enc_done) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FIN: begin
          enc_cs <= 1'b1;
          done   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_word_loader.sv
// Randomized and directed bench for word_loader against a queue-based model.
module tb_word_loader;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 2 ** AW;

  typedef logic [DW-1:0] byte_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cs;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          enc_cs;
  logic          enc_done;
  logic [AW:0]   count;
  logic          overflow;
  logic          done;

  int vectors     = 0;
  int miscompares = 0;

  logic [AW-1:0] wa_q[$];
  byte_t         wd_q[$];

  word_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (cs),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .enc_cs   (enc_cs),
    .enc_done (enc_done),
    .count    (count),
    .overflow (overflow),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Record every SRAM write; each single-cycle pulse is seen exactly once.
  always @(negedge clk) begin
    if (mem_we) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_din);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected SRAM image: zeros are kept only right after a non-zero entry,
  // payload is capped at DEPTH-2 entries, then zeros pad to a double zero.
  function automatic void model(input byte_t bs[$], output byte_t ex[$],
                                output bit ovf, output int terms);
    ex.delete();
    ovf = 1'b0;
    foreach (bs[i]) begin
      if (bs[i] != 0) begin
        if (ex.size() < DEPTH - 2) ex.push_back(bs[i]);
        else ovf = 1'b1;
      end else if (ex.size() > 0 && ex[ex.size()-1] != 0 && ex.size() < DEPTH - 2) begin
        ex.push_back(8'h00);
      end
    end
    terms = (ex.size() > 0 && ex[ex.size()-1] == 0) ? 1 : 2;
    repeat (terms) ex.push_back(8'h00);
  endfunction

  task automatic check_reset_values(input string name);
    chk({name, ":rst_rdy"}, in_ready, 0);
    chk({name, ":rst_we"},  mem_we,   0);
    chk({name, ":rst_adr"}, mem_addr, 0);
    chk({name, ":rst_din"}, mem_din,  0);
    chk({name, ":rst_ecs"}, enc_cs,   0);
    chk({name, ":rst_cnt"}, count,    0);
    chk({name, ":rst_ovf"}, overflow, 0);
    chk({name, ":rst_don"}, done,     0);
  endtask

  task automatic do_reset(input string name);
    rst_n    = 1'b0;
    cs       = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    enc_done = 1'b0;
    #1;
    check_reset_values(name);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic start_load(input string name);
    cs = 1'b1;
    @(posedge clk);
    #1;
    cs = 1'b0;
    chk({name, ":load_rdy"}, in_ready, 1);
  endtask

  task automatic run_stream(input string name, input byte_t bs[$], input bit gaps,
                            input int done_delay);
    byte_t ex[$];
    bit    ovf;
    int    terms;
    int    lat;
    int    nwr;
    model(bs, ex, ovf, terms);
    do_reset(name);
    start_load(name);
    foreach (bs[i]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          in_valid = 1'b0;
          in_data  = byte_t'($urandom);
          in_last  = $urandom_range(0, 1) == 1;
          @(posedge clk);
          #1;
        end
      end
      if (i == 0 || i == bs.size() - 1) chk({name, ":rdy"}, in_ready, 1);
      in_valid = 1'b1;
      in_data  = bs[i];
      in_last  = (i == bs.size() - 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    lat = 0;
    while (!enc_cs && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, ":enc_lat"}, lat, terms + 1);
    chk({name, ":count"}, count, ex.size());
    chk({name, ":ovf"}, overflow, ovf);
    chk({name, ":nwrites"}, wa_q.size(), ex.size());
    foreach (ex[i]) begin
      if (i < wa_q.size()) begin
        chk($sformatf("%s:addr%0d", name, i), wa_q[i], i);
        chk($sformatf("%s:data%0d", name, i), wd_q[i], ex[i]);
      end
    end
    nwr = wa_q.size();
    // Stray handshake and start activity while running must be ignored.
    repeat (done_delay) begin
      in_valid = 1'b1;
      in_data  = byte_t'($urandom_range(1, 255));
      cs       = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    cs       = 1'b0;
    chk({name, ":done_pre"}, done, 0);
    chk({name, ":ecs_run"}, enc_cs, 1);
    enc_done = 1'b1;
    @(posedge clk);
    #1;
    enc_done = 1'b0;
    chk({name, ":done"}, done, 1);
    chk({name, ":fin_rdy"}, in_ready, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk({name, ":done_hold"}, done, 1);
    chk({name, ":ecs_hold"}, enc_cs, 1);
    chk({name, ":no_extra_wr"}, wa_q.size(), nwr);
  endtask

  initial begin
    byte_t s[$];
    int    len;

    s = '{8'h61, 8'h62, 8'h00, 8'h63, 8'h64};
    run_stream("ab0cd", s, 1'b0, 5);

    s = '{8'h00, 8'h00, 8'h61, 8'h00, 8'h00, 8'h62};
    run_stream("zeros", s, 1'b0, 2);

    s = '{8'h00};
    run_stream("empty", s, 1'b0, 1);

    s.delete();
    for (int i = 0; i < 20; i++) s.push_back(byte_t'(i + 1));
    run_stream("ovfl", s, 1'b0, 3);

    s = '{8'h78, 8'h00};
    run_stream("x0_gaps", s, 1'b1, 5);

    for (int t = 0; t < 8; t++) begin
      s.delete();
      len = $urandom_range(1, 22);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 2) == 0) s.push_back(8'h00);
        else s.push_back(byte_t'($urandom_range(1, 255)));
      end
      run_stream($sformatf("rnd%0d", t), s, 1'b1, $urandom_range(1, 6));
    end

    // Asynchronous reset in the middle of a load.
    do_reset("mid0");
    start_load("mid0");
    in_valid = 1'b1;
    in_data  = 8'h41;
    @(posedge clk);
    #1;
    in_data  = 8'h42;
    @(posedge clk);
    #3;
    in_valid = 1'b0;
    chk("mid:pre_cnt", count, 2);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
